// File: rtl/seletor_mapas_n_if.sv
// Map-selector bus: packed map inputs, control strobes and registered display-side outputs.
// Strobes (carregar, proximo) are single-cycle pulses taken on the clock edge they are high; there is no back-pressure.
interface seletor_mapas_n_if #(
   parameter int N_MAPAS = 4,
   parameter int LARGURA = 7
);
   localparam int IW = (N_MAPAS > 2) ? $clog2(N_MAPAS) : 1;

   logic [N_MAPAS*LARGURA-1:0] mapas;
   logic [IW-1:0]              sel_in;
   logic                       carregar;
   logic                       proximo;
   logic                       auto_en;
   logic                       pisca_en;
   logic [LARGURA-1:0]         out;
   logic [IW-1:0]              idx_atual;
   logic                       troca;
   logic                       erro;

   modport master (
      output mapas, sel_in, carregar, proximo, auto_en, pisca_en,
      input  out, idx_atual, troca, erro
   );

   modport slave (
      input  mapas, sel_in, carregar, proximo, auto_en, pisca_en,
      output out, idx_atual, troca, erro
   );
endinterface

// File: rtl/seletor_mapas_n.sv
// N-way map selector with direct load, step, timed auto-scan, blink and change strobe.
// The output register is fed from the next-state index so out and idx_atual move together.
module seletor_mapas_n #(
   parameter int N_MAPAS = 4,
   parameter int LARGURA = 7,
   parameter int PERIODO = 50000000,
   parameter int PISCA   = 25000000
) (
   input  logic             clk,
   input  logic             reset,
   seletor_mapas_n_if.slave bus
);
   localparam int IW  = (N_MAPAS > 2) ? $clog2(N_MAPAS) : 1;
   localparam int IW1 = IW + 1;
   localparam int PW  = (PERIODO > 2) ? $clog2(PERIODO) : 1;
   localparam int BW  = (PISCA > 2) ? $clog2(PISCA) : 1;

   localparam logic [IW-1:0] IDX_ULT   = IW'(N_MAPAS - 1);
   localparam logic [IW:0]   IDX_LIM   = IW1'(N_MAPAS);
   localparam logic [PW-1:0] SCAN_ULT  = PW'(PERIODO - 1);
   localparam logic [BW-1:0] PISCA_ULT = BW'(PISCA - 1);

   localparam logic [0:0] FASE_VISIVEL = 1'b0;
   localparam logic [0:0] FASE_OCULTA  = 1'b1;

   logic [IW-1:0]      idx_q, idx_d;
   logic [LARGURA-1:0] out_q, out_d;
   logic               troca_q;
   logic               erro_q, erro_d;
   logic [PW-1:0]      scan_q, scan_d;
   logic [BW-1:0]      blink_q, blink_d;
   logic [0:0]         fase_q, fase_d;
   logic               tick;
   logic               mudou;

   logic [LARGURA-1:0] mapa [N_MAPAS];

   for (genvar k = 0; k < N_MAPAS; k++) begin : g_mapa
      assign mapa[k] = bus.mapas[k*LARGURA +: LARGURA];
   end

   function automatic logic [IW-1:0] seguinte(input logic [IW-1:0] i);
      return (i == IDX_ULT) ? '0 : i + IW'(1);
   endfunction

   // Priority carregar > proximo > auto tick; lower-priority events are dropped.
   always_comb begin
      idx_d  = idx_q;
      erro_d = 1'b0;
      tick   = bus.auto_en && (scan_q == SCAN_ULT);
      if (bus.carregar) begin
         if ({1'b0, bus.sel_in} < IDX_LIM) idx_d = bus.sel_in;
         else                              erro_d = 1'b1;
      end else if (bus.proximo || tick) begin
         idx_d = seguinte(idx_q);
      end
      mudou = (idx_d != idx_q);
   end

   // Any accepted strobe, valid or not, restarts the scan period.
   always_comb begin
      scan_d = scan_q + PW'(1);
      if (!bus.auto_en || bus.carregar || bus.proximo || tick) scan_d = '0;
   end

   // A new index always starts in the visible phase with a fresh half-period.
   always_comb begin
      blink_d = blink_q + BW'(1);
      fase_d  = fase_q;
      if (!bus.pisca_en || mudou) begin
         blink_d = '0;
         fase_d  = FASE_VISIVEL;
      end else if (blink_q == PISCA_ULT) begin
         blink_d = '0;
         fase_d  = (fase_q == FASE_VISIVEL) ? FASE_OCULTA : FASE_VISIVEL;
      end
      out_d = (fase_d == FASE_VISIVEL) ? mapa[idx_d] : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idx_q   <= '0;
         out_q   <= '0;
         troca_q <= 1'b0;
         erro_q  <= 1'b0;
         scan_q  <= '0;
         blink_q <= '0;
         fase_q  <= FASE_VISIVEL;
      end else begin
         idx_q   <= idx_d;
         out_q   <= out_d;
         troca_q <= mudou;
         erro_q  <= erro_d;
         scan_q  <= scan_d;
         blink_q <= blink_d;
         fase_q  <= fase_d;
      end
   end

   assign bus.out       = out_q;
   assign bus.idx_atual = idx_q;
   assign bus.troca     = troca_q;
   assign bus.erro      = erro_q;
endmodule

// File: tb/tb_seletor_mapas_n.sv
// Bench for seletor_mapas_n: a 4-map build checked against a cycle-level reference model,
// and a 3-map build used for the invalid-load case.
module tb_seletor_mapas_n;
   localparam int P  = 4;
   localparam int PS = 3;

   localparam logic [6:0] M0 = 7'b1000001;
   localparam logic [6:0] M1 = 7'b1100011;
   localparam logic [6:0] M2 = 7'b0111110;
   localparam logic [6:0] M3 = 7'b0010100;

   logic clk = 1'b0;
   logic reset = 1'b1;

   seletor_mapas_n_if #(.N_MAPAS(4), .LARGURA(7)) if4 ();
   seletor_mapas_n_if #(.N_MAPAS(3), .LARGURA(7)) if3 ();

   seletor_mapas_n #(.N_MAPAS(4), .LARGURA(7), .PERIODO(P), .PISCA(PS)) dut4 (
      .clk(clk), .reset(reset), .bus(if4.slave));
   seletor_mapas_n #(.N_MAPAS(3), .LARGURA(7), .PERIODO(P), .PISCA(PS)) dut3 (
      .clk(clk), .reset(reset), .bus(if3.slave));

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // reference model state for the 4-map build
   int         m_idx = 0;
   int         scan_age = 0;
   int         blink_age = 0;
   logic [6:0] m_out = '0;
   logic       m_troca = 1'b0;
   logic       m_erro = 1'b0;

   function automatic logic [6:0] map_of(input int k);
      return if4.mapas[k*7 +: 7];
   endfunction

   task automatic model_step();
      int old;
      if (reset) begin
         m_idx = 0; scan_age = 0; blink_age = 0;
         m_out = '0; m_troca = 1'b0; m_erro = 1'b0;
         return;
      end
      old = m_idx;
      m_erro = 1'b0;
      if (if4.carregar) begin
         if (int'(if4.sel_in) < 4) m_idx = int'(if4.sel_in);
         else m_erro = 1'b1;
      end else if (if4.proximo) begin
         m_idx = (m_idx + 1) % 4;
      end
      if (!if4.auto_en || if4.carregar || if4.proximo) begin
         scan_age = 0;
      end else begin
         scan_age++;
         if (scan_age == P) begin
            m_idx = (m_idx + 1) % 4;
            scan_age = 0;
         end
      end
      m_troca = (m_idx != old);
      if (!if4.pisca_en || m_troca) blink_age = 0;
      else blink_age++;
      m_out = (((blink_age / PS) % 2) == 0) ? map_of(m_idx) : 7'd0;
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle_inputs();
      if4.carregar = 1'b0; if4.proximo = 1'b0; if4.sel_in = '0;
      if3.carregar = 1'b0; if3.proximo = 1'b0; if3.sel_in = '0;
   endtask

   task automatic test_reset();
      logic [10:0] got, exp;
      reset = 1'b1;
      step();
      got = {if4.out, if4.idx_atual, if4.troca, if4.erro};
      n_cmp++;
      if (got !== 11'd0) begin
         n_err++; $display("FAIL reset_state: got %h expected %h", got, 11'd0);
      end
      reset = 1'b0;
      step();
      exp = {M0, 2'd0, 1'b0, 1'b0};
      got = {if4.out, if4.idx_atual, if4.troca, if4.erro};
      n_cmp++;
      if (got !== exp) begin
         n_err++; $display("FAIL after_reset: got %h expected %h", got, exp);
      end
   endtask

   task automatic test_load();
      logic [10:0] got, exp;
      for (int r = 0; r < 3; r++) begin
         if4.carregar = (r != 1); if4.sel_in = 2'd2;
         step();
         idle_inputs();
         exp = {M2, 2'd2, (r == 0), 1'b0};
         got = {if4.out, if4.idx_atual, if4.troca, if4.erro};
         n_cmp++;
         if (got !== exp) begin
            n_err++; $display("FAIL load_%0d: got %h expected %h", r, got, exp);
         end
      end
   endtask

   task automatic test_proximo();
      logic [1:0] seq [4];
      logic [10:0] got;
      seq[0] = 2'd3; seq[1] = 2'd0; seq[2] = 2'd1; seq[3] = 2'd2;
      for (int i = 0; i < 4; i++) begin
         if4.proximo = 1'b1;
         step();
         idle_inputs();
         got = {if4.idx_atual, if4.troca};
         n_cmp++;
         if (got[2:0] !== {seq[i], 1'b1}) begin
            n_err++; $display("FAIL proximo_%0d: got %h expected %h", i, got[2:0], {seq[i], 1'b1});
         end
      end
      if4.carregar = 1'b1; if4.proximo = 1'b1; if4.sel_in = 2'd0;
      step();
      idle_inputs();
      n_cmp++;
      if (if4.idx_atual !== 2'd0 || if4.out !== M0) begin
         n_err++; $display("FAIL load_beats_proximo: got idx %0d out %b expected idx 0 out %b", if4.idx_atual, if4.out, M0);
      end
   endtask

   task automatic test_auto();
      logic [1:0] exp_idx;
      if4.auto_en = 1'b1;
      exp_idx = 2'd0;
      for (int c = 1; c <= 16; c++) begin
         step();
         if (c % P == 0) exp_idx = exp_idx + 2'd1;
         n_cmp++;
         if (if4.idx_atual !== exp_idx || if4.troca !== (c % P == 0)) begin
            n_err++; $display("FAIL auto_c%0d: got idx %0d troca %b expected idx %0d troca %b", c, if4.idx_atual, if4.troca, exp_idx, (c % P == 0));
         end
      end
      step(); step();
      if4.proximo = 1'b1;
      step();
      idle_inputs();
      for (int c = 1; c <= 4; c++) begin
         step();
         exp_idx = (c == 4) ? 2'd2 : 2'd1;
         n_cmp++;
         if (if4.idx_atual !== exp_idx) begin
            n_err++; $display("FAIL auto_restart_c%0d: got %0d expected %0d", c, if4.idx_atual, exp_idx);
         end
      end
      n_cmp++;
      if (if4.idx_atual !== 2'(m_idx) || if4.out !== m_out) begin
         n_err++; $display("FAIL auto_model: got idx %0d out %b expected idx %0d out %b", if4.idx_atual, if4.out, m_idx, m_out);
      end
      if4.auto_en = 1'b0;
   endtask

   task automatic test_blink();
      logic [6:0] exp_o [7];
      exp_o[0] = M1; exp_o[1] = M1; exp_o[2] = 7'd0; exp_o[3] = M2;
      exp_o[4] = M2; exp_o[5] = M2; exp_o[6] = 7'd0;
      if4.carregar = 1'b1; if4.sel_in = 2'd1;
      step();
      idle_inputs();
      if4.pisca_en = 1'b1;
      for (int e = 0; e < 7; e++) begin
         if4.proximo = (e == 3);
         step();
         idle_inputs();
         n_cmp++;
         if (if4.out !== exp_o[e]) begin
            n_err++; $display("FAIL blink_e%0d: got %b expected %b", e, if4.out, exp_o[e]);
         end
      end
      if4.pisca_en = 1'b0;
      step();
      n_cmp++;
      if (if4.out !== M2) begin
         n_err++; $display("FAIL blink_off: got %b expected %b", if4.out, M2);
      end
   endtask

   task automatic test_random();
      logic [10:0] got, exp;
      for (int c = 0; c < 400; c++) begin
         if4.carregar = ($urandom_range(0, 7) == 0);
         if4.proximo  = ($urandom_range(0, 7) == 0);
         if4.sel_in   = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 15) == 0) if4.auto_en  = ~if4.auto_en;
         if ($urandom_range(0, 15) == 0) if4.pisca_en = ~if4.pisca_en;
         if ($urandom_range(0, 19) == 0) if4.mapas = 28'($urandom);
         reset = ($urandom_range(0, 99) == 0);
         step();
         reset = 1'b0;
         exp = {m_out, 2'(m_idx), m_troca, m_erro};
         got = {if4.out, if4.idx_atual, if4.troca, if4.erro};
         n_cmp++;
         if (got !== exp) begin
            n_err++; $display("FAIL random_c%0d: got %h expected %h", c, got, exp);
         end
      end
      idle_inputs();
      if4.auto_en = 1'b0; if4.pisca_en = 1'b0;
      if4.mapas = {M3, M2, M1, M0};
      step();
   endtask

   task automatic test_invalid();
      logic [10:0] got, exp;
      if3.carregar = 1'b1; if3.sel_in = 2'd2;
      step();
      idle_inputs();
      exp = {M2, 2'd2, 1'b1, 1'b0};
      got = {if3.out, if3.idx_atual, if3.troca, if3.erro};
      n_cmp++;
      if (got !== exp) begin
         n_err++; $display("FAIL n3_load_last: got %h expected %h", got, exp);
      end
      if3.carregar = 1'b1; if3.sel_in = 2'd3;
      step();
      idle_inputs();
      exp = {M2, 2'd2, 1'b0, 1'b1};
      got = {if3.out, if3.idx_atual, if3.troca, if3.erro};
      n_cmp++;
      if (got !== exp) begin
         n_err++; $display("FAIL n3_invalid: got %h expected %h", got, exp);
      end
      if3.proximo = 1'b1;
      step();
      idle_inputs();
      exp = {M0, 2'd0, 1'b1, 1'b0};
      got = {if3.out, if3.idx_atual, if3.troca, if3.erro};
      n_cmp++;
      if (got !== exp) begin
         n_err++; $display("FAIL n3_wrap: got %h expected %h", got, exp);
      end
   endtask

   task automatic test_reset_mid();
      logic [10:0] got;
      if4.auto_en = 1'b1; if4.pisca_en = 1'b1;
      if4.carregar = 1'b1; if4.sel_in = 2'd3;
      step();
      idle_inputs();
      for (int c = 0; c < 5; c++) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      got = {if4.out, if4.idx_atual, if4.troca, if4.erro};
      n_cmp++;
      if (got !== 11'd0) begin
         n_err++; $display("FAIL reset_mid: got %h expected %h", got, 11'd0);
      end
      got = {if3.out, if3.idx_atual, if3.troca, if3.erro};
      n_cmp++;
      if (got !== 11'd0) begin
         n_err++; $display("FAIL reset_mid_n3: got %h expected %h", got, 11'd0);
      end
      if4.auto_en = 1'b0; if4.pisca_en = 1'b0;
   endtask

   initial begin
      if4.mapas = {M3, M2, M1, M0};
      if4.auto_en = 1'b0; if4.pisca_en = 1'b0;
      if3.mapas = {M2, M1, M0};
      if3.auto_en = 1'b0; if3.pisca_en = 1'b0;
      idle_inputs();
      test_reset();
      test_load();
      test_proximo();
      test_auto();
      test_blink();
      test_invalid();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
